// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer for an up/down counter. Runs a one-shot countdown,
// a periodic reload countdown, or a 0..P..0 sweep on a start/stop handshake.
// All counter controls are combinational from the state registers and the
// counter's q, so the counter acts on them at the same clk edge this block does.
module counter_ctrl #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
  input  logic [n-1:0] period,
  input  logic [n-1:0] q_in,
  output logic [n-1:0] cnt_r,
  output logic         cnt_load,
  output logic         cnt_en,
  output logic         cnt_up_down,
  output logic         cnt_clr_n,
  output logic         busy,
  output logic         done,
  output logic         tick
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t       state, state_nx;
  logic [1:0]   mode_r;
  logic [n-1:0] period_r;
  logic         dir, dir_nx;
  logic         q_zero, q_top, p_zero;

  assign q_zero    = (q_in == '0);
  assign q_top     = (q_in == period_r);
  assign p_zero    = (period_r == '0);
  // The counter's clear follows our own reset so both come out of reset together.
  assign cnt_clr_n = ~clr;

  // State, captured run parameters and sweep direction.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      mode_r   <= 2'b00;
      period_r <= '0;
      dir      <= 1'b1;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
      if (state == IDLE && start) begin
        mode_r   <= mode;
        period_r <= period;
      end
    end
  end

  // Next state and counter controls; mode 11 falls through to one-shot.
  always_comb begin
    state_nx    = state;
    dir_nx      = dir;
    cnt_r       = '0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    cnt_up_down = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    tick        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          dir_nx   = 1'b1;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
        // The sweep starts from the bottom; the countdown modes start from P.
        cnt_r    = (mode_r == 2'b10) ? '0 : period_r;
        state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stop) begin
          state_nx = DONE;
        end else begin
          case (mode_r)
            2'b01: begin
              if (!q_zero) begin
                cnt_en = 1'b1;
              end else begin
                cnt_load = 1'b1;
                cnt_r    = period_r;
                tick     = 1'b1;
              end
            end
            2'b10: begin
              cnt_en      = 1'b1;
              cnt_up_down = dir;
              // At a turnaround step the other way on the same edge; with P=0
              // there is nowhere to step, so the counter holds.
              if (dir && q_top) begin
                tick        = 1'b1;
                dir_nx      = 1'b0;
                cnt_up_down = 1'b0;
                cnt_en      = ~p_zero;
              end else if (!dir && q_zero) begin
                tick        = 1'b1;
                dir_nx      = 1'b1;
                cnt_up_down = 1'b1;
                cnt_en      = ~p_zero;
              end
            end
            default: begin
              if (!q_zero) cnt_en = 1'b1;
              else         state_nx = DONE;
            end
          endcase
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: a behavioural up/down counter closes the loop; a
// vector table covers reset, one-shot and sweep; directed and random runs are
// checked against a phase/elapsed-cycle model with closed-form q trajectories.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] period = 8'd0;
  logic [7:0] q;
  logic [7:0] cnt_r;
  logic       cnt_load, cnt_en, cnt_up_down, cnt_clr_n, busy, done, tick;

  int checks = 0, errors = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.n(8)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .mode(mode),
    .period(period), .q_in(q), .cnt_r(cnt_r), .cnt_load(cnt_load),
    .cnt_en(cnt_en), .cnt_up_down(cnt_up_down), .cnt_clr_n(cnt_clr_n),
    .busy(busy), .done(done), .tick(tick)
  );

  // Counter being driven: sync active-low clear, load over enable.
  always_ff @(posedge clk) begin
    if (!cnt_clr_n)    q <= 8'd0;
    else if (cnt_load) q <= cnt_r;
    else if (cnt_en)   q <= cnt_up_down ? q + 8'd1 : q - 8'd1;
  end

  typedef struct {
    logic        c, s, p;
    logic [1:0]  md;
    logic [7:0]  per;
    logic [22:0] exp;   // {clr_n,busy,done,tick,load,en,ud,r[7:0],q[7:0]}
  } vec_t;

  function automatic vec_t mk(input logic c, s, p, input logic [1:0] md,
                              input logic [7:0] per, input logic clrn, bsy, dn,
                              tk, ld, en, ud, input logic [7:0] r, qq);
    vec_t v;
    v.c = c; v.s = s; v.p = p; v.md = md; v.per = per;
    v.exp = {clrn, bsy, dn, tk, ld, en, ud, r, qq};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, s, p, input logic [1:0] md, input logic [7:0] per);
    @(posedge clk); #1;
    clr = c; start = s; stop = p; mode = md; period = per;
    @(negedge clk);
  endtask

  // Reference model: phase (0 idle, 1 load, 2 run, 3 done) and cycles into RUN.
  int ph = 0, ri = 0, pp = 0, mm = 0;

  task automatic step(input logic c, s, p, input logic [1:0] md, input logic [7:0] per);
    logic eb, ed, et, el, ee, eu;
    logic [7:0] er;
    int eq, pos;
    bit fin;
    drive(c, s, p, md, per);
    eb = 0; ed = 0; et = 0; el = 0; ee = 0; eu = 0; er = 0; eq = 0; fin = 0;
    case (ph)
      1: begin eb = 1; el = 1; er = (mm == 2) ? 8'd0 : 8'(pp); end
      2: begin
        eb = 1;
        if (mm == 0) begin
          eq = pp - ri;
          if (eq != 0) ee = 1; else fin = 1;
        end else if (mm == 1) begin
          eq = pp - (ri % (pp + 1));
          if (eq != 0) ee = 1; else begin el = 1; er = 8'(pp); et = 1; end
        end else if (pp == 0) begin
          eq = 0; et = 1; eu = ri[0];
        end else begin
          pos = ri % (2 * pp);
          eq  = (pos <= pp) ? pos : 2 * pp - pos;
          ee  = 1;
          if (pos == pp)              begin et = 1; eu = 0; end
          else if (pos == 0 && ri > 0) begin et = 1; eu = 1; end
          else                              eu = (pos < pp);
        end
        if (p) begin ee = 0; el = 0; et = 0; eu = 0; er = 0; fin = 1; end
        chk("run_q", 32'(q), 32'(eq));
      end
      3: ed = 1;
      default: ;
    endcase
    chk("outputs", 32'({cnt_clr_n, busy, done, tick, cnt_load, cnt_en, cnt_up_down, cnt_r}),
        32'({~c, eb, ed, et, el, ee, eu, er}));
    if (tick) tick_cnt++;
    if (c) ph = 0;
    else case (ph)
      0: if (s) begin ph = 1; mm = (md == 2'b11) ? 0 : int'(md); pp = per; ri = 0; end
      1: ph = 2;
      2: if (fin) ph = 3; else ri++;
      default: ph = 0;
    endcase
  endtask

  vec_t tbl[22];
  logic [7:0] q_hold;

  initial begin
    // Reset, one-shot P=3 (mode/period wiggled mid-run), start in DONE ignored,
    // sweep P=3 with start during RUN ignored and stop at q=1.
    tbl[0]  = mk(1,0,0,0,0, 0,0,0,0,0,0,0, 0,0);
    tbl[1]  = mk(1,0,0,0,0, 0,0,0,0,0,0,0, 0,0);
    tbl[2]  = mk(0,1,0,0,3, 1,0,0,0,0,0,0, 0,0);
    tbl[3]  = mk(0,0,0,1,7, 1,1,0,0,1,0,0, 3,0);
    tbl[4]  = mk(0,0,0,1,7, 1,1,0,0,0,1,0, 0,3);
    tbl[5]  = mk(0,0,0,1,7, 1,1,0,0,0,1,0, 0,2);
    tbl[6]  = mk(0,0,0,1,7, 1,1,0,0,0,1,0, 0,1);
    tbl[7]  = mk(0,0,0,1,7, 1,1,0,0,0,0,0, 0,0);
    tbl[8]  = mk(0,1,0,0,3, 1,0,1,0,0,0,0, 0,0);
    tbl[9]  = mk(0,0,0,0,0, 1,0,0,0,0,0,0, 0,0);
    tbl[10] = mk(0,1,0,2,3, 1,0,0,0,0,0,0, 0,0);
    tbl[11] = mk(0,0,0,0,0, 1,1,0,0,1,0,0, 0,0);
    tbl[12] = mk(0,0,0,0,0, 1,1,0,0,0,1,1, 0,0);
    tbl[13] = mk(0,1,0,0,5, 1,1,0,0,0,1,1, 0,1);
    tbl[14] = mk(0,0,0,0,0, 1,1,0,0,0,1,1, 0,2);
    tbl[15] = mk(0,0,0,0,0, 1,1,0,1,0,1,0, 0,3);
    tbl[16] = mk(0,0,0,0,0, 1,1,0,0,0,1,0, 0,2);
    tbl[17] = mk(0,0,0,0,0, 1,1,0,0,0,1,0, 0,1);
    tbl[18] = mk(0,0,0,0,0, 1,1,0,1,0,1,1, 0,0);
    tbl[19] = mk(0,0,1,0,0, 1,1,0,0,0,0,0, 0,1);
    tbl[20] = mk(0,0,0,0,0, 1,0,1,0,0,0,0, 0,1);
    tbl[21] = mk(0,0,0,0,0, 1,0,0,0,0,0,0, 0,1);
    for (int k = 0; k < 22; k++) begin
      drive(tbl[k].c, tbl[k].s, tbl[k].p, tbl[k].md, tbl[k].per);
      chk($sformatf("vec%0d", k),
          32'({cnt_clr_n, busy, done, tick, cnt_load, cnt_en, cnt_up_down, cnt_r, q}),
          32'(tbl[k].exp));
    end

    // Periodic P=2 for three periods, then stop; q must stay frozen.
    ph = 0;
    step(0,1,0,1,2);
    step(0,0,0,0,0);
    tick_cnt = 0;
    for (int k = 0; k < 9; k++) step(0,0,0,0,0);
    chk("periodic_ticks", 32'(tick_cnt), 32'd3);
    step(0,0,1,0,0);
    q_hold = q;
    step(0,0,0,0,0);
    step(0,0,0,0,0);
    step(0,0,1,0,0);
    chk("stop_freeze", 32'(q), 32'(q_hold));

    // P=0 in every mode, including mode 11.
    for (int m = 0; m < 4; m++) begin
      step(0,1,0,2'(m),0);
      for (int k = 0; k < 4; k++) step(0,0,0,0,0);
      step(0,0,1,0,0);
      step(0,0,0,0,0);
      step(0,0,0,0,0);
    end

    // clr at q=5 during a periodic run: back to IDLE, counter cleared, no pulses.
    step(0,1,0,1,9);
    step(0,0,0,0,0);
    for (int k = 0; k < 4; k++) step(0,0,0,0,0);
    step(1,0,0,0,0);
    step(0,0,0,0,0);
    chk("clr_q_zero", 32'(q), 32'd0);
    chk("clr_no_pulse", 32'({done, tick, busy}), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      logic [7:0] per;
      per = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) per = 8'($urandom_range(7, 20));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)), per);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
